// File: rtl/glitch_clkgen.sv
// Divided clock generator with tick counter and a small table of exact-tick
// clock glitches (overclock bursts or clock stretches) plus aligned stop.
module glitch_clkgen #(
   parameter int DIV_WIDTH     = 4,
   parameter int COUNTER_WIDTH = 25,
   parameter int NUM_GLITCH    = 4,
   parameter int LEN_WIDTH     = 4,
   localparam int IDX_WIDTH    = (NUM_GLITCH > 1) ? $clog2(NUM_GLITCH) : 1
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear,
   input  logic [1:0]               stop_align,
   input  logic                     cfg_we,
   input  logic [IDX_WIDTH-1:0]     cfg_idx,
   input  logic                     cfg_en,
   input  logic                     cfg_mode,
   input  logic [COUNTER_WIDTH-1:0] cfg_tick,
   input  logic [LEN_WIDTH-1:0]     cfg_len,
   output logic                     clkout,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     running,
   output logic                     glitch_active,
   output logic [NUM_GLITCH-1:0]    glitch_done
);

   typedef enum logic [1:0] {IDLE, RUN, FAST, HOLD} state_t;

   localparam logic [DIV_WIDTH-1:0] MSB_MASK = DIV_WIDTH'(1) << (DIV_WIDTH - 1);

   state_t                   state_q, state_d;
   logic [DIV_WIDTH-1:0]     div_q, div_d;
   logic [COUNTER_WIDTH-1:0] cnt_d;
   logic [LEN_WIDTH-1:0]     rem_q, rem_d;
   logic [IDX_WIDTH-1:0]     idx_q, idx_d;
   logic                     pend_q, pend_d;
   logic [NUM_GLITCH-1:0]    set_done;
   logic                     tick;

   logic                     tbl_en   [NUM_GLITCH];
   logic                     tbl_mode [NUM_GLITCH];
   logic [COUNTER_WIDTH-1:0] tbl_tick [NUM_GLITCH];
   logic [LEN_WIDTH-1:0]     tbl_len  [NUM_GLITCH];

   logic                     hit;
   logic [IDX_WIDTH-1:0]     hit_idx;
   logic                     trig;

   assign clkout = div_q[DIV_WIDTH-1];

   // Ascending scan with a found flag gives lowest-index priority.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NUM_GLITCH; i++) begin
         if (!hit && tbl_en[i] && !glitch_done[i] && (count == tbl_tick[i])) begin
            hit     = 1'b1;
            hit_idx = IDX_WIDTH'(i);
         end
      end
   end

   assign trig = (state_q == RUN) && hit && !(cfg_we && (cfg_idx == hit_idx));

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      rem_d    = rem_q;
      idx_d    = idx_q;
      pend_d   = pend_q | (stop & (state_q != IDLE));
      set_done = '0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (!trig) begin
               div_d = div_q + DIV_WIDTH'(1);
            end else if (tbl_len[hit_idx] == '0) begin
               div_d             = div_q + DIV_WIDTH'(1);
               set_done[hit_idx] = 1'b1;
            end else if (!tbl_mode[hit_idx]) begin
               div_d = div_q ^ MSB_MASK;
               if (tbl_len[hit_idx] == LEN_WIDTH'(1)) begin
                  set_done[hit_idx] = 1'b1;
               end else begin
                  state_d = FAST;
                  rem_d   = tbl_len[hit_idx] - LEN_WIDTH'(1);
                  idx_d   = hit_idx;
               end
            end else begin
               div_d   = div_q + DIV_WIDTH'(1);
               state_d = HOLD;
               rem_d   = tbl_len[hit_idx];
               idx_d   = hit_idx;
            end
         end
         FAST: begin
            div_d = div_q ^ MSB_MASK;
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
               state_d         = RUN;
               set_done[idx_q] = 1'b1;
            end
         end
         HOLD: begin
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
               state_d         = RUN;
               set_done[idx_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      tick  = div_d[DIV_WIDTH-1] & ~div_q[DIV_WIDTH-1];
      cnt_d = count + COUNTER_WIDTH'(tick);

      // A stop completes only on a count-changing edge, so clkout is left high.
      if ((state_q == RUN) && !trig && pend_q && tick && (cnt_d[1:0] == stop_align)) begin
         state_d = IDLE;
         pend_d  = 1'b0;
      end

      if (clear) begin
         state_d = IDLE;
         div_d   = '0;
         cnt_d   = '0;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q       <= IDLE;
         div_q         <= '0;
         count         <= '0;
         rem_q         <= '0;
         idx_q         <= '0;
         pend_q        <= 1'b0;
         running       <= 1'b0;
         glitch_active <= 1'b0;
         glitch_done   <= '0;
         for (int unsigned i = 0; i < NUM_GLITCH; i++) begin
            tbl_en[i]   <= 1'b0;
            tbl_mode[i] <= 1'b0;
            tbl_tick[i] <= '0;
            tbl_len[i]  <= '0;
         end
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         count         <= cnt_d;
         rem_q         <= rem_d;
         idx_q         <= idx_d;
         pend_q        <= pend_d;
         running       <= (state_d != IDLE);
         glitch_active <= (state_d == FAST) || (state_d == HOLD);
         for (int unsigned i = 0; i < NUM_GLITCH; i++) begin
            if (cfg_we && (cfg_idx == IDX_WIDTH'(i))) glitch_done[i] <= 1'b0;
            else if (clear)                           glitch_done[i] <= 1'b0;
            else if (set_done[i])                     glitch_done[i] <= 1'b1;
         end
         if (cfg_we) begin
            tbl_en[cfg_idx]   <= cfg_en;
            tbl_mode[cfg_idx] <= cfg_mode;
            tbl_tick[cfg_idx] <= cfg_tick;
            tbl_len[cfg_idx]  <= cfg_len;
         end
      end
   end

endmodule
